// File: rtl/motor_pwm_driver.sv
// Slew-limited single-ended PWM motor driver with command watchdog.
// Duty only changes at period wraps so the output never glitches mid-period.
module motor_pwm_driver #(
    parameter int PRESCALE         = 1,
    parameter int SLEW_STEP        = 4,
    parameter int WATCHDOG_PERIODS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cmd_valid,
    input  logic [7:0] motor_command,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic       period_start,
    output logic       at_target,
    output logic       wdt_fault
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WW = (WATCHDOG_PERIODS > 1) ? $clog2(WATCHDOG_PERIODS) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [WW-1:0] WDT_MAX = WW'(WATCHDOG_PERIODS - 1);
    localparam logic [8:0]    STEP9   = 9'(SLEW_STEP);
    localparam logic [7:0]    STEP8   = 8'(SLEW_STEP);

    logic [PW-1:0] pre;
    logic [7:0]    cnt;
    logic [7:0]    target;
    logic [WW-1:0] wdt_cnt;

    logic          tick;
    logic          wrap;
    logic          up;
    logic [7:0]    eff_target;
    logic [8:0]    diff;
    logic [7:0]    step;
    logic [7:0]    duty_next;

    // Step is clamped to the remaining distance, so no overshoot or 8-bit wrap.
    always_comb begin
        eff_target = wdt_fault ? 8'd0 : target;
        tick       = (pre == PRE_MAX);
        wrap       = tick && (cnt == 8'd254);
        up         = (eff_target > duty);
        diff       = up ? ({1'b0, eff_target} - {1'b0, duty})
                        : ({1'b0, duty} - {1'b0, eff_target});
        step       = (diff < STEP9) ? diff[7:0] : STEP8;
        duty_next  = up ? (duty + step) : (duty - step);
    end

    assign at_target = (duty == eff_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= 8'd0;
            target       <= 8'd0;
            duty         <= 8'd0;
            wdt_cnt      <= '0;
            wdt_fault    <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            if (cmd_valid) begin
                target <= motor_command;
            end

            if (!enable) begin
                pre          <= '0;
                cnt          <= 8'd0;
                duty         <= 8'd0;
                wdt_cnt      <= '0;
                wdt_fault    <= 1'b0;
                period_start <= 1'b0;
                pwm_out      <= 1'b0;
            end else begin
                pre          <= tick ? '0 : pre + PW'(1);
                period_start <= wrap;
                pwm_out      <= (cnt < duty);

                if (tick) begin
                    cnt <= wrap ? 8'd0 : cnt + 8'd1;
                end

                if (wrap) begin
                    duty <= duty_next;
                end

                // A fresh command always beats expiry on the same edge.
                if (cmd_valid) begin
                    wdt_cnt   <= '0;
                    wdt_fault <= 1'b0;
                end else if (wrap) begin
                    if (wdt_cnt == WDT_MAX) begin
                        wdt_fault <= 1'b1;
                    end else begin
                        wdt_cnt <= wdt_cnt + WW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: vector rows of command/wraps/expected
// state, plus hand sequences for PWM shape, watchdog edge, enable and reset.
module tb_motor_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cmd_valid;
    logic [7:0] motor_command;
    logic       pwm_out;
    logic [7:0] duty;
    logic       period_start;
    logic       at_target;
    logic       wdt_fault;

    int total = 0;
    int bad   = 0;

    motor_pwm_driver #(
        .PRESCALE(1),
        .SLEW_STEP(4),
        .WATCHDOG_PERIODS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .cmd_valid(cmd_valid),
        .motor_command(motor_command),
        .pwm_out(pwm_out),
        .duty(duty),
        .period_start(period_start),
        .at_target(at_target),
        .wdt_fault(wdt_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       send;
        bit [7:0] cmd;
        int       wraps;
        bit [7:0] e_duty;
        bit       e_at;
        bit       e_fault;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    function automatic void add(bit s, bit [7:0] c, int w,
                                bit [7:0] d, bit a, bit f);
        vecs[nv].send    = s;
        vecs[nv].cmd     = c;
        vecs[nv].wraps   = w;
        vecs[nv].e_duty  = d;
        vecs[nv].e_at    = a;
        vecs[nv].e_fault = f;
        nv++;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic pulse_cmd(input bit [7:0] c);
        cmd_valid     = 1'b1;
        motor_command = c;
        @(negedge clk);
        cmd_valid     = 1'b0;
    endtask

    task automatic wait_wraps(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!period_start && k < 600);
            if (!period_start) begin
                check("wrap_timeout", 0, 1);
                return;
            end
        end
    endtask

    // Samples one full period starting right after a period_start sample.
    task automatic window(output int hi, output int ps_at);
        hi    = 0;
        ps_at = 0;
        for (int i = 1; i <= 255; i++) begin
            @(negedge clk);
            if (pwm_out) hi++;
            if (period_start) ps_at = i;
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].send) pulse_cmd(vecs[i].cmd);
            wait_wraps(vecs[i].wraps);
            check($sformatf("row%0d_duty", i), int'(duty), int'(vecs[i].e_duty));
            check($sformatf("row%0d_at", i), int'(at_target), int'(vecs[i].e_at));
            check($sformatf("row%0d_fault", i), int'(wdt_fault), int'(vecs[i].e_fault));
        end
    endtask

    initial begin
        int hi;
        int ps_at;
        int n;

        // ramp up 0 -> 100 (rows 0..5)
        add(1, 100, 1,   4, 0, 0);
        add(0,   0, 1,   8, 0, 0);
        add(0,   0, 8,  40, 0, 0);
        add(1, 100, 10, 80, 0, 0);
        add(1, 100, 4,  96, 0, 0);
        add(0,   0, 1, 100, 1, 0);
        // watchdog expiry and recovery (rows 6..12)
        add(1, 100, 15, 100, 1, 0);
        add(0,   0, 1, 100, 0, 1);
        add(0,   0, 1,  96, 0, 1);
        add(0,   0, 24,  0, 1, 1);
        add(1,  50, 1,   4, 0, 0);
        add(1,  50, 11, 48, 0, 0);
        add(1,  50, 1,  50, 1, 0);
        // up to 80 before enable drop (row 13)
        add(1,  80, 8,  80, 1, 0);
        // ramp down from 10 (rows 14..17)
        add(1,  10, 1,  10, 1, 0);
        add(1,   0, 1,   6, 0, 0);
        add(0,   0, 1,   2, 0, 0);
        add(0,   0, 1,   0, 1, 0);
        // ramp toward 100 before reset (row 18)
        add(1, 100, 10, 40, 0, 0);
        // ramp to 100 then saturate at 255 (rows 19..27)
        add(1, 100, 10, 40, 0, 0);
        add(1, 100, 10, 80, 0, 0);
        add(1, 100, 5, 100, 1, 0);
        add(1, 255, 1, 104, 0, 0);
        add(1, 255, 10, 144, 0, 0);
        add(1, 255, 10, 184, 0, 0);
        add(1, 255, 10, 224, 0, 0);
        add(1, 255, 7, 252, 0, 0);
        add(1, 255, 1, 255, 1, 0);

        rst           = 1'b1;
        enable        = 1'b0;
        cmd_valid     = 1'b0;
        motor_command = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_fault", int'(wdt_fault), 0);
        check("rst_at", int'(at_target), 1);

        enable = 1'b1;
        run_vecs(0, 6);

        window(hi, ps_at);
        check("pwm100_high", hi, 100);
        check("ps_spacing", ps_at, 255);

        run_vecs(6, 13);

        // command landing on the 16th wrap edge keeps the fault away
        pulse_cmd(8'd50);
        wait_wraps(15);
        check("pre16_fault", int'(wdt_fault), 0);
        repeat (254) @(negedge clk);
        cmd_valid     = 1'b1;
        motor_command = 8'd50;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("edge_wrap", int'(period_start), 1);
        check("edge_nofault", int'(wdt_fault), 0);
        wait_wraps(15);
        check("edge_15_fault", int'(wdt_fault), 0);
        wait_wraps(1);
        check("edge_16_fault", int'(wdt_fault), 1);
        check("edge_16_duty", int'(duty), 50);

        run_vecs(13, 14);

        // enable drop mid-period at duty 80
        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("en_pwm", int'(pwm_out), 0);
        check("en_duty", int'(duty), 0);
        check("en_ps", int'(period_start), 0);
        check("en_at", int'(at_target), 0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 600);
        check("en_restart_len", n, 255);
        check("en_duty1", int'(duty), 4);
        wait_wraps(1);
        check("en_duty2", int'(duty), 8);

        run_vecs(14, 18);
        window(hi, ps_at);
        check("pwm0_high", hi, 0);

        run_vecs(18, 19);

        // reset mid-ramp at duty 40, cnt 120
        repeat (120) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_duty", int'(duty), 0);
        check("mrst_pwm", int'(pwm_out), 0);
        check("mrst_ps", int'(period_start), 0);
        check("mrst_fault", int'(wdt_fault), 0);
        check("mrst_at", int'(at_target), 1);
        wait_wraps(1);
        check("mrst_target_lost", int'(duty), 0);

        run_vecs(19, 28);
        window(hi, ps_at);
        check("pwm255_high", hi, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Downstream stage of the RPU actuator path. Consumes the 8-bit `motor_command` produced by the RPU top level and turns it into a slew-limited, single-ended PWM signal for the motor power stage. A command watchdog forces the motor to stop when commands stop arriving. Duty changes only at PWM period boundaries, so the output never glitches mid-period.

## Interface
Parameters:
- `PRESCALE`, default 1: clocks per PWM counter tick; must be ≥1.
- `SLEW_STEP`, default 4: maximum duty change per PWM period; legal range 1–255.
- `WATCHDOG_PERIODS`, default 16: number of consecutive PWM periods without `cmd_valid` before a fault; must be ≥1.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: drive enable.
- `cmd_valid`, input, 1: `motor_command` is valid this cycle.
- `motor_command`, input, 8: requested duty, 0–255.
- `pwm_out`, output, 1: registered PWM drive.
- `duty`, output, 8: currently applied duty (register).
- `period_start`, output, 1: one-cycle pulse at the start of each PWM period.
- `at_target`, output, 1: `duty` equals the effective target (combinational from registers).
- `wdt_fault`, output, 1: watchdog expired (register).

## Operation
- **Target register**
  - Loads `motor_command` on any edge where `cmd_valid` is 1.
  - Effective target = 0 if `wdt_fault` is 1, else the target register.
- **Prescaler and tick**
  - Prescaler `pre` counts 0..PRESCALE-1.
  - `tick` = (`pre` == PRESCALE-1).
- **PWM counter**
  - `cnt` runs 0..254 and advances on `tick`.
  - `wrap` = `tick` and (`cnt` == 254); on wrap, `cnt` goes to 0.
  - Period length is 255·PRESCALE clocks.
- **Duty update (only on wrap edges)**
  - Let `d` = |effective target − `duty`|, computed at 9-bit width.
  - `duty` moves toward the target by min(SLEW_STEP, `d`).
  - There is no overshoot and no 8-bit wrap: an upward step from 252 with SLEW_STEP=4 toward 255 gives 255.
- **PWM output**
  - `pwm_out` is registered every clock as `enable` & (`cnt` < `duty`), using pre-edge register values.
  - Duty 0 gives a constant-low output; duty 255 gives a constant-high output.
- **period_start**
  - Registered; equals 1 in the cycle after each wrap edge.
  - Not asserted after reset until the first wrap.
- **Watchdog**
  - `wdt_cnt` counts wrap edges that have no `cmd_valid`.
  - On a wrap edge with no `cmd_valid` and `wdt_cnt` == WATCHDOG_PERIODS-1, `wdt_fault` sets and `wdt_cnt` saturates.
  - Any `cmd_valid` edge clears `wdt_cnt` and `wdt_fault`.
  - After a fault, `duty` ramps to 0 at SLEW_STEP per period.
- **Enable low (synchronous)**
  - On every edge with `enable`=0: `pre`, `cnt`, `duty`, `wdt_cnt` are set to 0; `wdt_fault` and `period_start` are cleared; `pwm_out` is set to 0.
  - The target register still loads on `cmd_valid`.
  - When `enable` returns to 1, counting restarts from `cnt`=0 and `duty` ramps from 0.
- **Simultaneous events**
  - Every edge decision uses pre-edge register values.
  - `cmd_valid` on a wrap edge: the duty step uses the old effective target, the new target is captured, and the watchdog clears. `cmd_valid` therefore takes priority over watchdog expiry.
  - `rst` takes priority over everything; `enable`=0 takes priority over `cmd_valid` for everything except the target load.

## Timing
- **Reset values**
  - Outputs: `pwm_out`=0, `duty`=0, `period_start`=0, `wdt_fault`=0, `at_target`=1.
  - Internal: `pre`, `cnt`, target register, `wdt_cnt` = 0.
- **Reset mid-operation:** all registers return to reset values at the next edge; no ramp-down.
- **Command to duty change:** a command captured at edge E first affects `duty` at the first wrap edge after E. That is up to 255·PRESCALE clocks away, or the same-period wrap when E precedes it.
- **duty to pwm_out:** `pwm_out` lags `cnt`/`duty` by one clock. The first high cycle of a period is the cycle after `cnt` becomes 0.
- **Full ramp:** a step from 0 to target T settles after ceil(T/SLEW_STEP) wraps; `at_target` rises combinationally with the final `duty` update.
- **Watchdog assertion:** with continuous `enable`, `wdt_fault` asserts on the WATCHDOG_PERIODS-th wrap edge after the last `cmd_valid`.

## Test plan
All scenarios use PRESCALE=1, SLEW_STEP=4, WATCHDOG_PERIODS=16 unless noted.

- **Ramp up:** reset; `enable`=1; a single `cmd_valid` with `motor_command`=100, re-sent every 10 periods.
  - `duty` steps 4, 8, …, 100 on successive wraps; `at_target`=1 after the 25th wrap.
  - `pwm_out` is high for exactly 100 of every 255 clocks.
  - `period_start` pulses every 255 clocks.
- **Saturation:** from `duty`=100, command 255.
  - `duty` goes 104 … 252, then 255 (no wrap); `pwm_out` is constantly high afterwards.
- **Ramp down:** from `duty`=10, command 0.
  - `duty` goes 6, 2, 0; `pwm_out` stays low for the whole period once `duty`=0.
- **Watchdog:** from `duty`=100, stop `cmd_valid`.
  - `wdt_fault`=1 on the 16th wrap; `duty` decreases by 4 per period to 0.
  - A `cmd_valid` with 50 clears the fault and the ramp returns to 50.
  - `cmd_valid` asserted on the 16th wrap edge itself prevents the fault.
- **Enable drop:** deassert `enable` mid-period at `duty`=80.
  - Next cycle: `pwm_out`=0, `duty`=0, `cnt`=0.
  - On reassert: ramps 4, 8, … from a fresh period.
- **Reset mid-ramp:** assert `rst` for one cycle at `duty`=40, `cnt`=120.
  - Next edge: all outputs at reset values and `at_target`=1; the old target is lost.
